// File: rtl/fpga_host_nbf_uart_bridge.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | fpga_host_nbf_uart_bridge                                               |
// | Byte <-> NBF packet bridge between the UART PHY and the FPGA host.      |
// | Option: FPGA_HOST_NBF_UART_BRIDGE_TIMEOUT_EN enables partial-RX timeout. |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module fpga_host_nbf_uart_bridge #(
   parameter  int nbf_addr_width_p = 40,
   parameter  int nbf_data_width_p = 64,
   parameter  int timeout_cycles_p = 4096,
   localparam int nbf_width_lp     = 8 + nbf_addr_width_p + nbf_data_width_p,
   localparam int nbf_bytes_lp     = nbf_width_lp / 8
) (
   input  logic                    clk_i,
   input  logic                    reset_active_low_i,

   input  logic                    rx_v_i,
   input  logic [7:0]              rx_i,
   input  logic                    rx_error_i,

   output logic [nbf_width_lp-1:0] nbf_o,
   output logic                    nbf_v_o,
   input  logic                    nbf_ready_and_i,

   input  logic [nbf_width_lp-1:0] nbf_i,
   input  logic                    nbf_v_i,
   output logic                    nbf_ready_and_o,

   output logic [7:0]              tx_o,
   output logic                    tx_v_o,
   input  logic                    tx_ready_and_i,

   output logic                    rx_error_o,
   output logic                    rx_overrun_o,
   output logic                    rx_resync_o
);

   localparam int c_cnt_w = $clog2(nbf_bytes_lp + 1);
   localparam logic [c_cnt_w-1:0] c_last_byte = c_cnt_w'(nbf_bytes_lp - 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // ------------------------------------------------------------------ RX
   logic [c_cnt_w-1:0]      r_rx_cnt;
   logic [nbf_width_lp-1:0] r_stage;
   logic [nbf_width_lp-1:0] r_nbf;
   logic                    r_nbf_v;
   logic                    r_rx_error;
   logic                    r_rx_overrun;

   logic                    w_byte_ok;
   logic                    w_pkt_done;
   logic                    w_deq;
   logic                    w_timeout;
   logic [nbf_width_lp-1:0] w_pkt;

   assign w_byte_ok  = rx_v_i & ~rx_error_i;
   assign w_pkt_done = w_byte_ok & (r_rx_cnt == c_last_byte);
   assign w_deq      = r_nbf_v & nbf_ready_and_i;
   // The final byte is the opcode, i.e. the top byte of the packet.
   assign w_pkt      = {rx_i, r_stage[nbf_width_lp-9:0]};

`ifdef FPGA_HOST_NBF_UART_BRIDGE_TIMEOUT_EN
   localparam int c_idle_w = $clog2(timeout_cycles_p + 1);

   logic [c_idle_w-1:0] r_idle;
   logic                r_resync;

   assign w_timeout = (r_rx_cnt != '0) && (r_idle == c_idle_w'(timeout_cycles_p));

   always_ff @(posedge clk_i or negedge reset_active_low_i) begin
      if (!reset_active_low_i) begin
         r_idle   <= '0;
         r_resync <= 1'b0;
      end else begin
         r_resync <= w_timeout & ~rx_error_i & ~rx_v_i;
         if (rx_v_i || rx_error_i || r_rx_cnt == '0 || w_timeout) begin
            r_idle <= '0;
         end else begin
            r_idle <= r_idle + 1'b1;
         end
      end
   end

   assign rx_resync_o = r_resync;
`else
   assign w_timeout   = 1'b0;
   assign rx_resync_o = 1'b0 & (timeout_cycles_p != 0);
`endif

   always_ff @(posedge clk_i or negedge reset_active_low_i) begin
      if (!reset_active_low_i) begin
         r_rx_cnt   <= '0;
         r_stage    <= '0;
         r_rx_error <= 1'b0;
      end else begin
         if (rx_error_i) begin
            r_rx_cnt   <= '0;
            r_rx_error <= 1'b1;
         end else if (rx_v_i) begin
            for (int k = 0; k < nbf_bytes_lp; k++) begin
               if (r_rx_cnt == c_cnt_w'(k)) begin
                  r_stage[8*k +: 8] <= rx_i;
               end
            end
            r_rx_cnt <= (r_rx_cnt == c_last_byte) ? '0 : r_rx_cnt + 1'b1;
         end else if (w_timeout) begin
            r_rx_cnt <= '0;
         end
      end
   end

   // One-entry output buffer; a completion may refill it on the dequeue cycle.
   always_ff @(posedge clk_i or negedge reset_active_low_i) begin
      if (!reset_active_low_i) begin
         r_nbf        <= '0;
         r_nbf_v      <= 1'b0;
         r_rx_overrun <= 1'b0;
      end else begin
         if (w_pkt_done) begin
            if (!r_nbf_v || w_deq) begin
               r_nbf   <= w_pkt;
               r_nbf_v <= 1'b1;
            end else begin
               r_rx_overrun <= 1'b1;
            end
         end else if (w_deq) begin
            r_nbf_v <= 1'b0;
         end
      end
   end

   assign nbf_o        = r_nbf;
   assign nbf_v_o      = r_nbf_v;
   assign rx_error_o   = r_rx_error;
   assign rx_overrun_o = r_rx_overrun;

   // ------------------------------------------------------------------ TX
   logic [0:0]              r_tx_state;
   logic [nbf_width_lp-1:0] r_shift;
   logic [c_cnt_w-1:0]      r_tx_cnt;

   always_ff @(posedge clk_i or negedge reset_active_low_i) begin
      if (!reset_active_low_i) begin
         r_tx_state <= ST_IDLE;
         r_shift    <= '0;
         r_tx_cnt   <= '0;
      end else begin
         case (r_tx_state)
            ST_IDLE: begin
               if (nbf_v_i) begin
                  r_shift    <= nbf_i;
                  r_tx_cnt   <= '0;
                  r_tx_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (tx_ready_and_i) begin
                  r_shift <= r_shift >> 8;
                  if (r_tx_cnt == c_last_byte) begin
                     r_tx_cnt   <= '0;
                     r_tx_state <= ST_IDLE;
                  end else begin
                     r_tx_cnt <= r_tx_cnt + 1'b1;
                  end
               end
            end
            default: r_tx_state <= ST_IDLE;
         endcase
      end
   end

   assign nbf_ready_and_o = (r_tx_state == ST_IDLE);
   assign tx_v_o          = (r_tx_state == ST_SEND);
   assign tx_o            = (r_tx_state == ST_SEND) ? r_shift[7:0] : 8'h00;

endmodule
`default_nettype wire

// File: doc/fpga_host_nbf_uart_bridge.md
# fpga_host_nbf_uart_bridge

Device-side endpoint of the host NBF-over-UART link. Assembles the byte stream from `uart_rx` into complete NBF packets for the FPGA host engine, and serializes response NBF packets from that engine into bytes for `uart_tx`. Sits between the UART PHY blocks and the host command/response logic inside the top-level FPGA wrapper.

## Interface
Parameters:
- `nbf_addr_width_p`, 40, NBF address field width
- `nbf_data_width_p`, 64, NBF data field width
- `nbf_width_lp`, 8+addr+data (=112), packed NBF width; must be a multiple of 8
- `nbf_bytes_lp`, nbf_width_lp/8 (=14), bytes per packet
- `timeout_cycles_p`, 4096, idle cycles before a partial RX packet is discarded (used only with the timeout feature)

Ports:
- `clk_i` in 1: single clock
- `reset_active_low_i` in 1: reset, asynchronous, active-low
- `rx_v_i` in 1: byte valid from uart_rx; one-cycle pulse, no backpressure
- `rx_i` in 8: received byte
- `rx_error_i` in 1: framing/parity error pulse from uart_rx
- `nbf_o` out nbf_width_lp: assembled packet {opcode[7:0], addr, data}, MSB-first
- `nbf_v_o` out 1: packet valid
- `nbf_ready_and_i` in 1: consumer accepts packet
- `nbf_i` in nbf_width_lp: response packet
- `nbf_v_i` in 1: response valid
- `nbf_ready_and_o` out 1: bridge accepts response
- `tx_o` out 8: byte to uart_tx
- `tx_v_o` out 1: byte valid
- `tx_ready_and_i` in 1: uart_tx accepts byte
- `rx_error_o` out 1: sticky, any rx_error_i since reset
- `rx_overrun_o` out 1: sticky, a completed packet was dropped
- `rx_resync_o` out 1: one-cycle pulse when a partial packet is discarded by timeout

## Operation
- Byte order (both directions): byte k carries bits [8k+:8] of the packed packet; byte 0 (data LSB) first, byte 13 (opcode) last.
- RX assembly: byte counter `rx_cnt` 0..nbf_bytes_lp-1; each `rx_v_i` writes `rx_i` into staging[8*rx_cnt+:8] and increments the counter. On the byte with `rx_cnt`=nbf_bytes_lp-1, counter wraps to 0 and the staging register is transferred to the output register.
- Output register: one-entry buffer. `nbf_v_o` high while full; cleared on `nbf_v_o & nbf_ready_and_i`. Staging continues collecting the next packet while the output is held.
- Overrun: a packet completes while the output is full and not being dequeued that same cycle -> new packet dropped, output unchanged, `rx_overrun_o` set. Completion in the same cycle as dequeue -> new packet loaded, no overrun.
- RX error: `rx_error_i` -> `rx_cnt` cleared, partial packet discarded, `rx_error_o` set. If `rx_v_i` and `rx_error_i` coincide, the error wins and the byte is discarded.
- TX FSM states: IDLE, SEND.
  - IDLE: `nbf_ready_and_o`=1. On `nbf_v_i` load shift register, `tx_cnt`=0, go SEND.
  - SEND: `tx_v_o`=1, `tx_o`=shift[7:0]. On `tx_ready_and_i`: shift right 8, increment; after byte nbf_bytes_lp-1 go IDLE.
- RX and TX paths are fully independent.

## Timing
- Reset values: `nbf_v_o`=0, `nbf_o`=0, `nbf_ready_and_o`=1, `tx_v_o`=0, `tx_o`=0, `rx_error_o`=0, `rx_overrun_o`=0, `rx_resync_o`=0; counters 0; TX state IDLE.
- RX latency: `nbf_v_o` high the cycle after the final byte's `rx_v_i`.
- TX: `tx_v_o` high the cycle after the `nbf_v_i & nbf_ready_and_o` handshake; `nbf_ready_and_o` returns high the cycle after the final byte handshake. Back-to-back responses are separated by one idle cycle.
- `tx_o` stays stable while `tx_v_o` is high and not accepted.
- Sticky flags are cleared only by reset. A reset mid-packet discards all partial state immediately (asynchronously).

## Configuration
- `FPGA_HOST_NBF_UART_BRIDGE_TIMEOUT_EN`: when defined, an idle counter runs while `rx_cnt`≠0, cleared on each `rx_v_i`. When it reaches `timeout_cycles_p`, `rx_cnt` is cleared and `rx_resync_o` pulses for one cycle. When not defined, there is no counter, `rx_resync_o` is tied 0, and partial packets wait indefinitely.

## Test plan
- Send 14 bytes encoding opcode 0x03, addr 0x00_8000_0000, data 0xAB -> one cycle after the last byte, `nbf_v_o`=1 and `nbf_o` = {8'h03, 40'h0080000000, 64'hAB}; cleared after the ready handshake.
- Drive `nbf_i` = {8'h02, 40'h0080000000, 64'hAB} with `tx_ready_and_i` toggling every other cycle -> bytes AB,00×7,00,00,00,80,00,02 emitted in order; `nbf_ready_and_o` low throughout.
- Hold `nbf_ready_and_i`=0 and send two packets -> the first is held, `rx_overrun_o`=1; then complete a third in the same cycle as a dequeue -> the third is loaded with no new overrun.
- Send 5 bytes, pulse `rx_error_i`, then a full packet -> `rx_error_o`=1 and the packet decodes correctly.
- With the timeout macro and `timeout_cycles_p`=16: send 3 bytes, idle 16 cycles -> `rx_resync_o` pulses once; the next 14 bytes decode correctly.
- Assert reset after 7 RX bytes and 3 TX bytes -> all outputs return to reset values; the next packet decodes correctly.
